keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows (fixed keymap valid only for 4).
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns (fixed keymap valid only for 4).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clocks each row is driven.
REQ-004 SHALL have parameter DEB_CYC, default 20000, consecutive stable clocks for press/release acceptance.
REQ-005 SHALL have parameter SPEED_W, default 8, width of speed value.
REQ-006 SHALL have parameter MAX_SPEED, default 100, clamp ceiling for committed speed.
REQ-007 SHALL have parameter DIGITS, default 3, maximum digits per entry.
REQ-008 SHALL have ports: clk_Keypad in 1 system clock; rst_n in 1 reset; one clock, reset asynchronous and active-low.
REQ-009 SHALL have ports: row_drv out ROWS one-hot active-high row drive; col_in in COLS active-high column sense (pre-synchronised externally).
REQ-010 SHALL have ports: key_valid out 1 one-cycle pulse per accepted key; key_code out $clog2(ROWS*COLS) code = row*COLS+col.
REQ-011 SHALL have ports: speed out SPEED_W committed speed; turn out 1 direction (1 right, 0 left); isDone out 1 one-cycle commit pulse; entry out SPEED_W pending value.

Function
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: row index advances (wrapping ROWS-1 to 0) every SCAN_DIV clocks; col_in sampled in last dwell cycle.
REQ-014 SCAN->DEBOUNCE when the sample has exactly one bit set; zero or multiple bits keep scanning; row_drv frozen outside SCAN.
REQ-015 DEBOUNCE: counter counts clocks with col_in equal to captured pattern; mismatch -> SCAN (next row); reaching DEB_CYC -> HELD.
REQ-016 HELD entry cycle: key_valid=1 for exactly one clock with key_code; remain until col_in==0 -> RELEASE.
REQ-017 RELEASE: DEB_CYC consecutive zero clocks -> SCAN next row; any nonzero resets count, stays RELEASE.
REQ-018 Keymap 4x4 rows 0..3: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D".
REQ-019 Digit key: if digit count < DIGITS, entry <= min(entry*10+digit, MAX_SPEED) computed at SPEED_W+4 bits; else ignored.
REQ-020 '#': speed <= entry, isDone pulses one clock coincident with speed update, entry and digit count cleared; '#' with zero digits leaves speed unchanged, no isDone.
REQ-021 '*': entry and digit count cleared, speed unchanged.
REQ-022 'A': turn<=1; 'B': turn<=0; 'C': turn<=~turn; 'D': speed<=0 and entry cleared immediately, isDone pulses.
REQ-023 Key actions take effect in the clock following key_valid.

Reset
REQ-024 rst_n low asynchronously forces: state SCAN, row index 0, row_drv=1, counters 0, key_valid=0, key_code=0, speed=0, turn=0, isDone=0, entry=0.
REQ-025 Reset mid-DEBOUNCE/HELD discards the pending key; no key_valid after release.

Configuration
REQ-026 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, digit/A/B keys re-emit key_valid every 8*DEB_CYC clocks after an initial 32*DEB_CYC hold; undefined: exactly one key_valid per press.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, key-code constants (KEY_0..KEY_9, KEY_STAR, KEY_HASH, KEY_A..KEY_D) and code-to-digit function.
REQ-028 Sub-module keypad_entry SHALL hold the REQ-019..REQ-022 value/direction logic; scan/debounce FSM stays in top.

Verification (SCAN_DIV=4, DEB_CYC=8)
REQ-029 Press '5' (row1,col1) steady 20 clocks, release -> one key_valid, key_code=5, entry=5.
REQ-030 Keys 7,5,# -> speed=75, isDone one pulse; keys 2,5,0,# -> speed=100 (clamped).
REQ-031 Bounce col_in 3 clocks on/off then steady -> single key_valid after 8 stable clocks.
REQ-032 Two columns high in same row -> no key_valid, scanning continues.
REQ-033 Keys 1,2,3,4 then # -> speed=100 (fourth digit ignored, 123 clamped); then B -> turn=0, C -> turn=1.
REQ-034 rst_n low during HELD -> all outputs zero immediately, row_drv=1, no key_valid on release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key-code constants for the 4x4 keypad scanner.
// Key codes are row*COLS+col on the fixed keymap:
//   row 0: 1 2 3 A   row 1: 4 5 6 B   row 2: 7 8 9 C   row 3: * 0 # D
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    // Decimal value of a digit key; non-digit keys map to zero.
    function automatic logic [3:0] code_to_digit(input logic [3:0] code);
        logic [3:0] d;
        case (code)
            KEY_0:   d = 4'd0;
            KEY_1:   d = 4'd1;
            KEY_2:   d = 4'd2;
            KEY_3:   d = 4'd3;
            KEY_4:   d = 4'd4;
            KEY_5:   d = 4'd5;
            KEY_6:   d = 4'd6;
            KEY_7:   d = 4'd7;
            KEY_8:   d = 4'd8;
            KEY_9:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // True for the ten numeric keys.
    function automatic logic is_digit(input logic [3:0] code);
        logic r;
        case (code)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Keys that may auto-repeat while held: digits and the direction keys A/B.
    function automatic logic is_repeatable(input logic [3:0] code);
        return is_digit(code) || (code == KEY_A) || (code == KEY_B);
    endfunction

endpackage

// File: rtl/keypad_entry.sv
// Speed entry / direction logic driven by accepted key codes.
// Digits accumulate into a clamped pending value, '#' commits it to speed,
// '*' clears the pending value, A/B/C steer direction and D forces a stop.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SPEED_W   = 8,
    parameter int MAX_SPEED = 100,
    parameter int DIGITS    = 3,
    parameter int KW        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [KW-1:0]      key_code,
    output logic [SPEED_W-1:0] speed,
    output logic               turn,
    output logic               is_done,
    output logic [SPEED_W-1:0] entry
);

    localparam int AW  = SPEED_W + 4;
    localparam int CNW = $clog2(DIGITS + 1);

    logic [3:0]         code_s;
    logic [3:0]         digit_s;
    logic [AW-1:0]      acc_s;
    logic [SPEED_W-1:0] clamp_s;
    logic [CNW-1:0]     dig_cnt_r;

    // Next pending value: entry*10 + digit at widened precision, clamped to the ceiling.
    always_comb begin
        code_s  = 4'(key_code);
        digit_s = code_to_digit(code_s);
        acc_s   = AW'(entry) * AW'(10) + AW'(digit_s);
        clamp_s = (acc_s > AW'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : acc_s[SPEED_W-1:0];
    end

    // Apply the action of each accepted key on the clock after key_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed     <= {SPEED_W{1'b0}};
            turn      <= 1'b0;
            is_done   <= 1'b0;
            entry     <= {SPEED_W{1'b0}};
            dig_cnt_r <= {CNW{1'b0}};
        end else begin
            is_done <= 1'b0;
            if (key_valid) begin
                if (is_digit(code_s)) begin
                    if (dig_cnt_r < CNW'(DIGITS)) begin
                        entry     <= clamp_s;
                        dig_cnt_r <= dig_cnt_r + CNW'(1);
                    end
                end else begin
                    case (code_s)
                        KEY_HASH: begin
                            if (dig_cnt_r != {CNW{1'b0}}) begin
                                speed     <= entry;
                                is_done   <= 1'b1;
                                entry     <= {SPEED_W{1'b0}};
                                dig_cnt_r <= {CNW{1'b0}};
                            end
                        end
                        KEY_STAR: begin
                            entry     <= {SPEED_W{1'b0}};
                            dig_cnt_r <= {CNW{1'b0}};
                        end
                        KEY_A: turn <= 1'b1;
                        KEY_B: turn <= 1'b0;
                        KEY_C: turn <= ~turn;
                        KEY_D: begin
                            speed     <= {SPEED_W{1'b0}};
                            is_done   <= 1'b1;
                            entry     <= {SPEED_W{1'b0}};
                            dig_cnt_r <= {CNW{1'b0}};
                        end
                        default: begin
                            dig_cnt_r <= dig_cnt_r;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one row at a time, debounces a single
// pressed key, emits a one-cycle key_valid and feeds the entry logic.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (held digit/A/B keys
// repeat after a long initial hold); without it each press yields one key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_CYC   = 20000,
    parameter int SPEED_W   = 8,
    parameter int MAX_SPEED = 100,
    parameter int DIGITS    = 3
) (
    input  logic                          clk_Keypad,
    input  logic                          rst_n,
    output logic [ROWS-1:0]               row_drv,
    input  logic [COLS-1:0]               col_in,
    output logic                          key_valid,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic [SPEED_W-1:0]            speed,
    output logic                          turn,
    output logic                          isDone,
    output logic [SPEED_W-1:0]            entry
);

    localparam int KW = $clog2(ROWS * COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEB_CYC + 1);
    localparam logic [ROWS-1:0] ROW0 = ROWS'(1);

    state_t         state_r;
    logic [RW-1:0]  row_idx_r;
    logic [DW-1:0]  div_cnt_r;
    logic [BW-1:0]  deb_cnt_r;
    logic [COLS-1:0] cap_r;
    logic [RW-1:0]  row_next_s;
    logic [CW-1:0]  col_idx_s;
    logic [KW-1:0]  code_s;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int AW = $clog2(32 * DEB_CYC + 1);
    logic [AW-1:0] rep_cnt_r;
    logic          rep_first_r;
    logic [AW-1:0] rep_lim_s;
    assign rep_lim_s = rep_first_r ? AW'(32 * DEB_CYC - 1) : AW'(8 * DEB_CYC - 1);
`endif

    // Next row (wrapping) and the code of the captured one-hot column pattern.
    always_comb begin
        row_next_s = (row_idx_r == RW'(ROWS - 1)) ? {RW{1'b0}} : row_idx_r + RW'(1);
        col_idx_s  = {CW{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            col_idx_s = col_idx_s | (cap_r[i] ? CW'(i) : {CW{1'b0}});
        end
        code_s = KW'(int'(row_idx_r) * COLS + int'(col_idx_s));
    end

    // Scan / debounce / held / release state machine with registered outputs.
    always_ff @(posedge clk_Keypad or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= SCAN;
            row_idx_r <= {RW{1'b0}};
            row_drv   <= ROW0;
            div_cnt_r <= {DW{1'b0}};
            deb_cnt_r <= {BW{1'b0}};
            cap_r     <= {COLS{1'b0}};
            key_valid <= 1'b0;
            key_code  <= {KW{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_r   <= {AW{1'b0}};
            rep_first_r <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (div_cnt_r == DW'(SCAN_DIV - 1)) begin
                        div_cnt_r <= {DW{1'b0}};
                        if ($onehot(col_in)) begin
                            cap_r     <= col_in;
                            deb_cnt_r <= {BW{1'b0}};
                            state_r   <= DEBOUNCE;
                        end else begin
                            row_idx_r <= row_next_s;
                            row_drv   <= ROW0 << row_next_s;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_in == cap_r) begin
                        if (deb_cnt_r == BW'(DEB_CYC - 1)) begin
                            deb_cnt_r <= {BW{1'b0}};
                            key_valid <= 1'b1;
                            key_code  <= code_s;
                            state_r   <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_r   <= {AW{1'b0}};
                            rep_first_r <= 1'b1;
`endif
                        end else begin
                            deb_cnt_r <= deb_cnt_r + BW'(1);
                        end
                    end else begin
                        deb_cnt_r <= {BW{1'b0}};
                        row_idx_r <= row_next_s;
                        row_drv   <= ROW0 << row_next_s;
                        state_r   <= SCAN;
                    end
                end
                HELD: begin
                    if (col_in == {COLS{1'b0}}) begin
                        deb_cnt_r <= {BW{1'b0}};
                        state_r   <= RELEASE;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (is_repeatable(4'(key_code))) begin
                            if (rep_cnt_r == rep_lim_s) begin
                                rep_cnt_r   <= {AW{1'b0}};
                                rep_first_r <= 1'b0;
                                key_valid   <= 1'b1;
                            end else begin
                                rep_cnt_r <= rep_cnt_r + AW'(1);
                            end
                        end else begin
                            rep_cnt_r <= {AW{1'b0}};
                        end
`else
                        state_r <= HELD;
`endif
                    end
                end
                RELEASE: begin
                    if (col_in == {COLS{1'b0}}) begin
                        if (deb_cnt_r == BW'(DEB_CYC - 1)) begin
                            deb_cnt_r <= {BW{1'b0}};
                            div_cnt_r <= {DW{1'b0}};
                            row_idx_r <= row_next_s;
                            row_drv   <= ROW0 << row_next_s;
                            state_r   <= SCAN;
                        end else begin
                            deb_cnt_r <= deb_cnt_r + BW'(1);
                        end
                    end else begin
                        deb_cnt_r <= {BW{1'b0}};
                    end
                end
                default: begin
                    state_r <= SCAN;
                end
            endcase
        end
    end

    keypad_entry #(
        .SPEED_W   (SPEED_W),
        .MAX_SPEED (MAX_SPEED),
        .DIGITS    (DIGITS),
        .KW        (KW)
    ) u_entry (
        .clk       (clk_Keypad),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .speed     (speed),
        .turn      (turn),
        .is_done   (isDone),
        .entry     (entry)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEB_CYC=8.
// A switch model turns the pressed key into col_in when its row is driven;
// expected key codes and commit speeds are queued by the stimulus and
// popped by a monitor whenever key_valid / isDone appear.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_drv;
    logic [3:0] col_in;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] speed;
    logic       turn;
    logic       isDone;
    logic [7:0] entry;

    logic       key_down;
    int         key_row;
    logic [3:0] key_mask;
    logic [3:0] seen;

    int total = 0;
    int bad   = 0;
    int exp_key_q[$];
    int exp_done_q[$];
    int mon_e;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_CYC(8),
        .SPEED_W(8), .MAX_SPEED(100), .DIGITS(3)
    ) dut (
        .clk_Keypad (clk),
        .rst_n      (rst_n),
        .row_drv    (row_drv),
        .col_in     (col_in),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .speed      (speed),
        .turn       (turn),
        .isDone     (isDone),
        .entry      (entry)
    );

    // Switch matrix: the pressed key connects its row drive to its column(s).
    always_comb col_in = (key_down && row_drv[key_row]) ? key_mask : 4'b0000;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every key_valid / isDone pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                if (exp_key_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_key_valid: got code %0d expected no pulse", key_code);
                end else begin
                    mon_e = exp_key_q.pop_front();
                    check("key_code", int'(key_code), mon_e);
                end
            end
            if (isDone) begin
                if (exp_done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_isDone: got speed %0d expected no pulse", speed);
                end else begin
                    mon_e = exp_done_q.pop_front();
                    check("commit_speed", int'(speed), mon_e);
                end
            end
        end
    end

    task automatic press(input int code);
        exp_key_q.push_back(code);
        key_row  = code / 4;
        key_mask = 4'b0001 << (code % 4);
        key_down = 1'b1;
        repeat (40) @(negedge clk);
        key_down = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        key_down = 1'b0;
        key_row  = 0;
        key_mask = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_row_drv", int'(row_drv), 1);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_speed", int'(speed), 0);
        check("rst_turn", int'(turn), 0);
        check("rst_isDone", int'(isDone), 0);
        check("rst_entry", int'(entry), 0);
        rst_n = 1'b1;

        // idle scanning walks all rows
        seen = 4'b0000;
        repeat (16) begin @(negedge clk); seen = seen | row_drv; end
        check("idle_rows_seen", int'(seen), 15);

        press(5);                               // '5'
        check("entry_after_5", int'(entry), 5);
        press(12);                              // '*'
        check("entry_after_star", int'(entry), 0);

        // bouncing '1' yields one key only
        exp_key_q.push_back(0);
        key_row = 0; key_mask = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            key_down = 1'b1; repeat (3) @(negedge clk);
            key_down = 1'b0; repeat (3) @(negedge clk);
        end
        key_down = 1'b1; repeat (40) @(negedge clk);
        key_down = 1'b0; repeat (20) @(negedge clk);
        check("entry_after_bounce", int'(entry), 1);
        press(12);

        press(8); press(5);                     // 7,5
        check("entry_75", int'(entry), 75);
        exp_done_q.push_back(75);
        press(14);                              // '#'
        check("speed_75", int'(speed), 75);
        check("entry_cleared", int'(entry), 0);

        press(1); press(5); press(13);          // 2,5,0
        check("entry_clamped", int'(entry), 100);
        exp_done_q.push_back(100);
        press(14);
        check("speed_100", int'(speed), 100);
        press(14);                              // '#' with no digits: no commit
        check("speed_after_empty_hash", int'(speed), 100);

        // two columns in one row: no key, scan continues
        key_row = 0; key_mask = 4'b0110; key_down = 1'b1;
        seen = 4'b0000;
        repeat (40) begin @(negedge clk); seen = seen | row_drv; end
        key_down = 1'b0;
        repeat (10) @(negedge clk);
        check("multi_col_rows_seen", int'(seen), 15);

        press(0);                               // '1'
        exp_done_q.push_back(0);
        press(15);                              // 'D'
        check("speed_after_D", int'(speed), 0);
        check("entry_after_D", int'(entry), 0);

        press(0); press(1); press(2); press(4); // 1,2,3,4
        check("entry_123_clamped", int'(entry), 100);
        exp_done_q.push_back(100);
        press(14);
        check("speed_1234", int'(speed), 100);

        press(3);  check("turn_A", int'(turn), 1);
        press(7);  check("turn_B", int'(turn), 0);
        press(11); check("turn_C", int'(turn), 1);

        // reset while '9' is held
        exp_key_q.push_back(10);
        key_row = 2; key_mask = 4'b0100; key_down = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("hrst_row_drv", int'(row_drv), 1);
        check("hrst_key_code", int'(key_code), 0);
        check("hrst_speed", int'(speed), 0);
        check("hrst_turn", int'(turn), 0);
        check("hrst_entry", int'(entry), 0);
        check("hrst_isDone", int'(isDone), 0);
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        check("keys_outstanding", exp_key_q.size(), 0);
        check("commits_outstanding", exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
